hyperram_device_model: RTL and testbench

- Synthesizable single-clock HyperRAM responder: the memory-device end of the HyperRAM bus that the `hyperram` controller initiates on.
- Decodes the 48-bit command/address sent on dq, counts fixed initial latency, then accepts masked write bytes or drives read bytes with an rwds strobe.
- Backed by a small internal word array.
- Used as the far-end model in unit tests and formal cover runs, and as an on-chip loopback target.

---
 rtl/hyperram_device_model.sv | 110 +++++++++++
 tb/tb_hyperram_device_model.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_device_model.sv
// hyperram_device_model: HyperRAM memory-device responder with a small internal word array
module hyperram_device_model #(
  parameter int          ADDR_WIDTH = 6,
  parameter int          LATENCY    = 6,
  parameter logic [15:0] ID0_VALUE  = 16'h0C81
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic [7:0] dq_in,
  input  logic       rwds_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  output logic       rwds_out,
  output logic       rwds_oe,
  output logic       busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [2:0] IDLE = 3'd0, CA = 3'd1, LAT = 3'd2, WR = 3'd3, RD = 3'd4;
  logic [2:0]            r_state;
  logic [47:0]           r_ca;
  logic [2:0]            r_ca_cnt;
  logic [5:0]            r_lat_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_byte_sel;
  logic [15:0]           r_mem [DEPTH];
  logic [31:0]           w_ca_word;
  logic [ADDR_WIDTH-1:0] w_ca_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_sel;
  logic [15:0]           w_rd_word;
  logic [7:0]            w_rd_byte;
  logic                  w_unused;
  assign w_ca_word = {r_ca[44:16], r_ca[2:0]};
  assign w_ca_addr = w_ca_word[ADDR_WIDTH-1:0];
  assign w_unused  = &{1'b0, r_ca[45], r_ca[15:3], w_ca_word};
  assign w_rd_sel  = (r_state == LAT) ? 1'b0 : ~r_byte_sel;
  assign w_rd_addr = (r_state == LAT) ? w_ca_addr : r_addr + ADDR_WIDTH'(r_byte_sel);
  assign w_rd_word = r_ca[46] ? ID0_VALUE : r_mem[w_rd_addr];
  assign w_rd_byte = w_rd_sel ? w_rd_word[7:0] : w_rd_word[15:8];
  assign busy      = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ca_cnt   <= '0;
      r_lat_cnt  <= '0;
      r_addr     <= '0;
      r_byte_sel <= 1'b0;
      dq_out     <= 8'h00;
      dq_oe      <= 1'b0;
      rwds_out   <= 1'b0;
      rwds_oe    <= 1'b0;
    end else if (cs_n) begin
      r_state   <= IDLE;
      r_ca_cnt  <= '0;
      r_lat_cnt <= '0;
      dq_oe     <= 1'b0;
      rwds_oe   <= 1'b0;
      rwds_out  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ca     <= {40'd0, dq_in};
          r_ca_cnt <= 3'd1;
          r_state  <= CA;
          rwds_oe  <= 1'b1;
          rwds_out <= 1'b0;
        end
        CA: begin
          r_ca     <= {r_ca[39:0], dq_in};
          r_ca_cnt <= r_ca_cnt + 3'd1;
          if (r_ca_cnt == 3'd5) begin
            r_state   <= LAT;
            r_lat_cnt <= '0;
            rwds_oe   <= 1'b0;
          end
        end
        LAT: begin
          r_lat_cnt <= r_lat_cnt + 6'd1;
          if (r_lat_cnt == 6'(LATENCY - 1)) begin
            r_state    <= r_ca[47] ? RD : WR;
            r_addr     <= w_ca_addr;
            r_byte_sel <= 1'b0;
            dq_oe      <= r_ca[47];
            rwds_oe    <= r_ca[47];
            rwds_out   <= r_ca[47];
            dq_out     <= r_ca[47] ? w_rd_byte : 8'h00;
          end
        end
        WR: begin
          r_byte_sel <= ~r_byte_sel;
          r_addr     <= r_addr + ADDR_WIDTH'(r_byte_sel);
        end
        RD: begin
          r_byte_sel <= ~r_byte_sel;
          r_addr     <= r_addr + ADDR_WIDTH'(r_byte_sel);
          dq_out     <= w_rd_byte;
          rwds_out   <= ~w_rd_sel;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst && !cs_n && r_state == WR && !rwds_in && !r_ca[46]) begin
      if (r_byte_sel) r_mem[r_addr][7:0] <= dq_in;
      else r_mem[r_addr][15:8] <= dq_in;
    end
  end
endmodule

// File: tb/tb_hyperram_device_model.sv
// tb_hyperram_device_model: directed table, corner sequences and random traffic against a byte-level memory model
module tb_hyperram_device_model;
  localparam int AW = 6;
  localparam int LATC = 6;
  localparam int DEPTH = 64;
  typedef struct {
    bit          rd;
    logic [47:0] ca;
    int          n;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] e;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] dq_in = 8'h00;
  logic       rwds_in = 1'b0;
  logic [7:0] dq_out;
  logic       dq_oe, rwds_out, rwds_oe, busy;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [15:0] model [DEPTH];
  logic [7:0]  wr_d [128];
  logic        wr_m [128];
  logic [7:0]  exp_b [8];
  vec_t        tbl [12];
  always #5 clk = ~clk;
  hyperram_device_model #(.ADDR_WIDTH(AW), .LATENCY(LATC), .ID0_VALUE(16'h0C81)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .dq_in(dq_in), .rwds_in(rwds_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .rwds_out(rwds_out), .rwds_oe(rwds_oe), .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int ca_word(input logic [47:0] ca);
    return int'({ca[18:16], ca[2:0]});
  endfunction
  task automatic send_ca(input logic [47:0] ca);
    for (int i = 0; i < 6; i++) begin
      cs_n = 1'b0;
      dq_in = ca[47-8*i -: 8];
      rwds_in = 1'b0;
      step();
      if (i == 0) begin
        check("ca_busy", {31'd0, busy}, 1);
        check("ca_rwds_oe", {31'd0, rwds_oe}, 1);
      end
    end
  endtask
  task automatic wait_lat();
    for (int i = 0; i < LATC; i++) begin
      dq_in = 8'($urandom);
      if (i == LATC - 1) check("lat_dq_oe", {31'd0, dq_oe}, 0);
      step();
    end
  endtask
  task automatic model_exp(input logic [47:0] ca, input int n);
    for (int j = 0; j < n; j++) begin
      int w;
      w = (ca_word(ca) + j / 2) % DEPTH;
      if (ca[46]) exp_b[j] = (j % 2 == 1) ? 8'h81 : 8'h0C;
      else exp_b[j] = (j % 2 == 1) ? model[w][7:0] : model[w][15:8];
    end
  endtask
  task automatic do_write(input logic [47:0] ca, input int n);
    send_ca(ca);
    wait_lat();
    for (int j = 0; j < n; j++) begin
      dq_in = wr_d[j];
      rwds_in = wr_m[j];
      step();
    end
    cs_n = 1'b1;
    rwds_in = 1'b0;
    step();
    check("wr_end_busy", {31'd0, busy}, 0);
    if (!ca[46]) begin
      for (int j = 0; j < n; j++) begin
        int w;
        w = (ca_word(ca) + j / 2) % DEPTH;
        if (!wr_m[j]) begin
          if (j % 2 == 1) model[w][7:0] = wr_d[j];
          else model[w][15:8] = wr_d[j];
        end
      end
    end
  endtask
  task automatic do_read(input logic [47:0] ca, input int n);
    send_ca(ca);
    wait_lat();
    for (int j = 0; j < n; j++) begin
      cs_n = 1'b0;
      dq_in = 8'($urandom);
      check("rd_dq_oe", {31'd0, dq_oe}, 1);
      check("rd_dq_out", {24'd0, dq_out}, {24'd0, exp_b[j]});
      check("rd_rwds", {31'd0, rwds_out}, (j % 2 == 0) ? 1 : 0);
      step();
    end
    cs_n = 1'b1;
    step();
    check("rd_end_busy", {31'd0, busy}, 0);
    check("rd_end_dq_oe", {31'd0, dq_oe}, 0);
  endtask
  initial begin
    logic [47:0] ca;
    logic [5:0]  a;
    int          n;
    tbl[0]  = '{rd: 1'b0, ca: 48'h0000_0000_0003, n: 4, d: 32'hABCD_1234, m: 4'b0000, e: 32'h0};
    tbl[1]  = '{rd: 1'b1, ca: 48'h8000_0000_0003, n: 4, d: 32'h0, m: 4'b0000, e: 32'hABCD_1234};
    tbl[2]  = '{rd: 1'b0, ca: 48'h0000_0000_0005, n: 2, d: 32'hAAAA_0000, m: 4'b0000, e: 32'h0};
    tbl[3]  = '{rd: 1'b0, ca: 48'h0000_0000_0005, n: 2, d: 32'h1122_0000, m: 4'b0001, e: 32'h0};
    tbl[4]  = '{rd: 1'b1, ca: 48'h8000_0000_0005, n: 2, d: 32'h0, m: 4'b0000, e: 32'hAA22_0000};
    tbl[5]  = '{rd: 1'b0, ca: 48'h0000_0007_0007, n: 4, d: 32'h0102_0304, m: 4'b0000, e: 32'h0};
    tbl[6]  = '{rd: 1'b1, ca: 48'h8000_0007_0007, n: 2, d: 32'h0, m: 4'b0000, e: 32'h0102_0000};
    tbl[7]  = '{rd: 1'b1, ca: 48'h8000_0000_0000, n: 2, d: 32'h0, m: 4'b0000, e: 32'h0304_0000};
    tbl[8]  = '{rd: 1'b1, ca: 48'hC000_0000_0000, n: 4, d: 32'h0, m: 4'b0000, e: 32'h0C81_0C81};
    tbl[9]  = '{rd: 1'b0, ca: 48'h4000_0000_0003, n: 2, d: 32'hFFFF_0000, m: 4'b0000, e: 32'h0};
    tbl[10] = '{rd: 1'b1, ca: 48'h8000_0000_0003, n: 2, d: 32'h0, m: 4'b0000, e: 32'hABCD_0000};
    tbl[11] = '{rd: 1'b1, ca: 48'hA000_0000_0003, n: 4, d: 32'h0, m: 4'b0000, e: 32'hABCD_1234};
    rst = 1'b0;
    cs_n = 1'b0;
    dq_in = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_dq_oe", {31'd0, dq_oe}, 0);
      check("rst_rwds_oe", {31'd0, rwds_oe}, 0);
      check("rst_dq_out", {24'd0, dq_out}, 0);
    end
    rst = 1'b1;
    cs_n = 1'b1;
    step();
    for (int j = 0; j < 128; j++) begin
      wr_d[j] = 8'($urandom);
      wr_m[j] = 1'b0;
    end
    do_write(48'h0000_0000_0000, 128);
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 4; j++) begin
        wr_d[j] = tbl[i].d[31-8*j -: 8];
        wr_m[j] = tbl[i].m[j];
        exp_b[j] = tbl[i].e[31-8*j -: 8];
      end
      if (tbl[i].rd) do_read(tbl[i].ca, tbl[i].n);
      else do_write(tbl[i].ca, tbl[i].n);
    end
    send_ca(48'h0000_0000_0003);
    for (int i = 0; i < 3; i++) begin
      dq_in = 8'h5A;
      step();
    end
    check("abort_busy_lat", {31'd0, busy}, 1);
    cs_n = 1'b1;
    step();
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_rwds_oe", {31'd0, rwds_oe}, 0);
    exp_b[0] = 8'hAB;
    exp_b[1] = 8'hCD;
    do_read(48'h8000_0000_0003, 2);
    wr_d[0] = 8'h5A;
    wr_m[0] = 1'b0;
    do_write(48'h0000_0000_0004, 1);
    exp_b[0] = 8'h5A;
    exp_b[1] = 8'h34;
    do_read(48'h8000_0000_0004, 2);
    send_ca(48'h8000_0000_0003);
    wait_lat();
    check("rst_rd_oe_before", {31'd0, dq_oe}, 1);
    step();
    rst = 1'b0;
    step();
    check("rst_rd_dq_oe", {31'd0, dq_oe}, 0);
    check("rst_rd_busy", {31'd0, busy}, 0);
    check("rst_rd_rwds_oe", {31'd0, rwds_oe}, 0);
    rst = 1'b1;
    cs_n = 1'b1;
    step();
    send_ca(48'h0000_0000_0007);
    wait_lat();
    dq_in = 8'hE1;
    rwds_in = 1'b0;
    step();
    rst = 1'b0;
    dq_in = 8'hE2;
    step();
    rst = 1'b1;
    cs_n = 1'b1;
    step();
    model[7][15:8] = 8'hE1;
    model_exp(48'h8000_0000_0007, 2);
    do_read(48'h8000_0000_0007, 2);
    for (int t = 0; t < 40; t++) begin
      a = 6'($urandom_range(0, 63));
      ca[47:32] = 16'($urandom);
      ca[31:0] = $urandom;
      ca[18:16] = a[5:3];
      ca[2:0] = a[2:0];
      ca[46] = ($urandom_range(0, 7) == 0);
      ca[47] = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      if (ca[47]) begin
        model_exp(ca, n);
        do_read(ca, n);
      end else begin
        for (int j = 0; j < n; j++) begin
          wr_d[j] = 8'($urandom);
          wr_m[j] = ($urandom_range(0, 3) == 0);
        end
        do_write(ca, n);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
